// File: rtl/bg_tile_fetch_seq_pkg.sv
// Shared PPU definitions for the background tile fetch sequencer: state encoding,
// VRAM map constants and small address/attribute helpers.
package bg_tile_fetch_seq_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_NT_REQ  = 4'd1;
    localparam logic [3:0] ST_NT_WAIT = 4'd2;
    localparam logic [3:0] ST_AT_REQ  = 4'd3;
    localparam logic [3:0] ST_AT_WAIT = 4'd4;
    localparam logic [3:0] ST_PL_REQ  = 4'd5;
    localparam logic [3:0] ST_PL_WAIT = 4'd6;
    localparam logic [3:0] ST_PH_REQ  = 4'd7;
    localparam logic [3:0] ST_PH_WAIT = 4'd8;
    localparam logic [3:0] ST_OUT     = 4'd9;

    localparam logic [15:0] NT_BASE_ADDR        = 16'h2000;
    localparam logic [15:0] NT_BASE_MASK        = 16'hFC00;
    localparam logic [15:0] ATTR_OFFSET_DEFAULT = 16'h03C0;
    localparam logic [15:0] PLANE_HI_OFFSET     = 16'h0008;

    // Each attribute byte covers a 32x32 area; quadrant q picks bits [2q+1:2q].
    function automatic logic [1:0] attr_quadrant(input logic [7:0] at_byte,
                                                 input logic       row4,
                                                 input logic       col4);
        logic [1:0] q;
        q = {row4, col4};
        case (q)
            2'd0:    return at_byte[1:0];
            2'd1:    return at_byte[3:2];
            2'd2:    return at_byte[5:4];
            default: return at_byte[7:6];
        endcase
    endfunction

    function automatic logic [15:0] pattern_addr(input logic       table_sel,
                                                 input logic [7:0] tile_num,
                                                 input logic [2:0] fine_y);
        return {3'b000, table_sel, tile_num, 1'b0, fine_y};
    endfunction

endpackage

// File: rtl/bg_tile_fetch_seq_pixel_to_nametable_ptr.sv
// Maps a scrolled 512x512 pixel position onto one of four 1 KiB nametables and
// returns the VRAM address of the tile entry under it.
module pixel_to_nametable_ptr
    import bg_tile_fetch_seq_pkg::*;
(
    input  logic [8:0]  pixel_row,
    input  logic [8:0]  pixel_col,
    input  logic [1:0]  nt_select,
    output logic [15:0] nt_addr
);

    logic nt_x;
    logic nt_y;

    // Crossing a 256-pixel boundary toggles to the neighbouring nametable.
    assign nt_x = nt_select[0] ^ pixel_col[8];
    assign nt_y = nt_select[1] ^ pixel_row[8];

    assign nt_addr = NT_BASE_ADDR | {4'b0000, nt_y, nt_x, pixel_row[7:3], pixel_col[7:3]};

endmodule

// File: rtl/bg_tile_fetch_seq.sv
// Background tile fetch sequencer: for each scanline fetches nametable, attribute and
// both pattern planes per tile from VRAM and hands each tile to the shifter.
module bg_tile_fetch_seq
    import bg_tile_fetch_seq_pkg::*;
#(
    parameter int unsigned TILES_PER_LINE = 33,
    parameter logic [15:0] ATTR_OFFSET    = ATTR_OFFSET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_line,
    input  logic [8:0]  screen_row,
    input  logic [15:0] cpu_scroll_addr,
    input  logic [7:0]  ppu_ctrl1,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    input  logic        vram_gnt,
    input  logic [7:0]  vram_rdata,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [7:0]  tile_pat_lo,
    output logic [7:0]  tile_pat_hi,
    output logic [1:0]  tile_attr,
    output logic        busy,
    output logic        line_done
);

    localparam int unsigned IDX_W = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [8:0]       row_q;
    logic [15:0]      scroll_q;
    logic [1:0]       nt_sel_q;
    logic             pat_sel_q;
    logic [IDX_W-1:0] tile_idx_q;
    logic [7:0]       nt_byte_q;
    logic [7:0]       pat_lo_q;
    logic [7:0]       pat_hi_q;
    logic [1:0]       attr_q;
    logic             line_done_q;

    logic [8:0]  tile_col;
    logic [8:0]  pixel_row;
    logic [8:0]  pixel_col;
    logic [15:0] nt_addr;
    logic [15:0] at_addr;
    logic [15:0] pl_addr;
    logic        last_tile;
    logic        handoff;
    logic        unused_ctrl_bits;

    assign unused_ctrl_bits = ^{ppu_ctrl1[7:5], ppu_ctrl1[3], ppu_ctrl1[0]};

    assign tile_col  = 9'({tile_idx_q, 3'b000});
    assign pixel_row = row_q + {1'b0, scroll_q[15:8]};
    assign pixel_col = tile_col + {1'b0, scroll_q[7:0]};
    assign last_tile = (tile_idx_q == IDX_W'(TILES_PER_LINE - 1));
    assign handoff   = (state_q == ST_OUT) && tile_ready;

    pixel_to_nametable_ptr u_nt_ptr (
        .pixel_row (pixel_row),
        .pixel_col (pixel_col),
        .nt_select (nt_sel_q),
        .nt_addr   (nt_addr)
    );

    assign at_addr = (nt_addr & NT_BASE_MASK) + ATTR_OFFSET
                   + {10'b0, pixel_row[7:5], 3'b000} + {13'b0, pixel_col[7:5]};
    assign pl_addr = pattern_addr(pat_sel_q, nt_byte_q, pixel_row[2:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_line) state_d = ST_NT_REQ;
            ST_NT_REQ:  if (vram_gnt) state_d = ST_NT_WAIT;
            ST_NT_WAIT: state_d = ST_AT_REQ;
            ST_AT_REQ:  if (vram_gnt) state_d = ST_AT_WAIT;
            ST_AT_WAIT: state_d = ST_PL_REQ;
            ST_PL_REQ:  if (vram_gnt) state_d = ST_PL_WAIT;
            ST_PL_WAIT: state_d = ST_PH_REQ;
            ST_PH_REQ:  if (vram_gnt) state_d = ST_PH_WAIT;
            ST_PH_WAIT: state_d = ST_OUT;
            ST_OUT:     if (tile_ready) state_d = last_tile ? ST_IDLE : ST_NT_REQ;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vram_addr = '0;
        case (state_q)
            ST_NT_REQ: vram_addr = nt_addr;
            ST_AT_REQ: vram_addr = at_addr;
            ST_PL_REQ: vram_addr = pl_addr;
            ST_PH_REQ: vram_addr = pl_addr + PLANE_HI_OFFSET;
            default:   vram_addr = '0;
        endcase
    end

    assign vram_req = (state_q == ST_NT_REQ) || (state_q == ST_AT_REQ) ||
                      (state_q == ST_PL_REQ) || (state_q == ST_PH_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            scroll_q    <= '0;
            nt_sel_q    <= '0;
            pat_sel_q   <= 1'b0;
            tile_idx_q  <= '0;
            nt_byte_q   <= '0;
            pat_lo_q    <= '0;
            pat_hi_q    <= '0;
            attr_q      <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_done_q <= handoff && last_tile;
            // Line parameters are snapshotted so CPU writes mid-line cannot disturb it.
            if ((state_q == ST_IDLE) && start_line) begin
                row_q      <= screen_row;
                scroll_q   <= cpu_scroll_addr;
                nt_sel_q   <= ppu_ctrl1[2:1];
                pat_sel_q  <= ppu_ctrl1[4];
                tile_idx_q <= '0;
            end
            if (state_q == ST_NT_WAIT) nt_byte_q <= vram_rdata;
            if (state_q == ST_AT_WAIT) begin
                attr_q <= attr_quadrant(vram_rdata, pixel_row[4], pixel_col[4]);
            end
            if (state_q == ST_PL_WAIT) pat_lo_q <= vram_rdata;
            if (state_q == ST_PH_WAIT) pat_hi_q <= vram_rdata;
            if (handoff && !last_tile) tile_idx_q <= tile_idx_q + 1'b1;
        end
    end

    assign tile_valid  = (state_q == ST_OUT);
    assign busy        = (state_q != ST_IDLE);
    assign line_done   = line_done_q;
    assign tile_pat_lo = pat_lo_q;
    assign tile_pat_hi = pat_hi_q;
    assign tile_attr   = attr_q;

endmodule
